// File: rtl/vend_coin_if.sv
// Coin bus between a payment initiator and the vending machine.
// Carries the payment request handshake, the coin/sell/change exchange with
// the machine, and the completion report.
//   req_valid/req_amt/req_ready : payment request handshake
//   coin                        : coin code toward the machine
//   sell/change                 : machine response
//   busy/done/done_*            : payment status and outcome
interface vend_coin_if #(
    parameter int unsigned AMT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic [1:0]       coin;
    logic             sell;
    logic [1:0]       change;
    logic             busy;
    logic             done;
    logic             done_err;
    logic [1:0]       done_change;
    logic [AMT_W-1:0] done_coins;
    logic [AMT_W-1:0] done_left;

    // Payer side
    modport master (
        input  req_valid, req_amt, sell, change,
        output req_ready, coin, busy, done, done_err, done_change,
               done_coins, done_left
    );

    // Front-end / machine side
    modport slave (
        output req_valid, req_amt, sell, change,
        input  req_ready, coin, busy, done, done_err, done_change,
               done_coins, done_left
    );
endinterface

// File: rtl/vend_coin_payer.sv
// Customer-side coin payer: takes a payment request in half-units, feeds
// coins (greedy 1.0 then 0.5) one per slot to the vending machine, watches
// for sell/change and reports the outcome with a one-cycle done pulse.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : vend_coin_if master (request in, coin out, sell/change in,
//           busy/done/done_* out); every output is registered
module vend_coin_payer #(
    parameter int unsigned AMT_W   = 4,
    parameter int unsigned GAP     = 1,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rstn,
    vend_coin_if.master  bus
);

    localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [AMT_W-1:0]   rem, rem_d;
    logic [AMT_W-1:0]   coins, coins_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [AMT_W-1:0]   coin_val;
    logic [1:0]         coin_d;
    logic               err_d;
    logic               sold;

    logic               req_ready_q;
    logic [1:0]         coin_q;
    logic               busy_q;
    logic               done_q;
    logic               done_err_q;
    logic [1:0]         done_change_q;
    logic [AMT_W-1:0]   done_coins_q;
    logic [AMT_W-1:0]   done_left_q;

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        rem_d    = rem;
        coins_d  = coins;
        timer_d  = timer;
        gap_d    = gap_cnt;
        err_d    = 1'b0;
        sold     = 1'b0;
        coin_val = (rem >= AMT_W'(2)) ? AMT_W'(2) : AMT_W'(1);
        coin_d   = 2'b00;

        case (state)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    rem_d   = bus.req_amt;
                    coins_d = '0;
                    timer_d = '0;
                    if (bus.req_amt == '0) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                // The coin on the wire this cycle is always counted, even if
                // the machine sells on it.
                rem_d   = rem - coin_val;
                coins_d = coins + AMT_W'(1);
                if (bus.sell) begin
                    state_d = S_DONE;
                    sold    = 1'b1;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (rem_d != '0) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (bus.sell) begin
                    state_d = S_DONE;
                    sold    = 1'b1;
                end else if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_d = (rem != '0) ? S_SEND : S_WAIT;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.sell) begin
                    state_d = S_DONE;
                    sold    = 1'b1;
                end else begin
                    timer_d = timer + TMR_W'(1);
                    if (timer_d == TMR_W'(TIMEOUT)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Coin register is loaded on entry to SEND so it is on the wire
        // exactly during the SEND cycle.
        if (state_d == S_SEND) begin
            coin_d = (rem_d >= AMT_W'(2)) ? 2'b10 : 2'b01;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            rem           <= '0;
            coins         <= '0;
            timer         <= '0;
            gap_cnt       <= '0;
            req_ready_q   <= 1'b1;
            coin_q        <= 2'b00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            done_change_q <= 2'b00;
            done_coins_q  <= '0;
            done_left_q   <= '0;
        end else begin
            state       <= state_d;
            rem         <= rem_d;
            coins       <= coins_d;
            timer       <= timer_d;
            gap_cnt     <= gap_d;
            req_ready_q <= (state_d == S_IDLE);
            coin_q      <= coin_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            // Outcome is captured on the way into DONE and held afterwards
            if (state_d == S_DONE && state != S_DONE) begin
                done_err_q    <= err_d;
                done_change_q <= sold ? bus.change : 2'b00;
                done_coins_q  <= coins_d;
                done_left_q   <= rem_d;
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.coin        = coin_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_err    = done_err_q;
    assign bus.done_change = done_change_q;
    assign bus.done_coins  = done_coins_q;
    assign bus.done_left   = done_left_q;

endmodule

// File: tb/tb_vend_coin_payer.sv
// Bench for vend_coin_payer: a GAP=1 instance driven from a vector table with
// a simple vending-machine model, plus a GAP=0 instance and reset corners.
module tb_vend_coin_payer;

    localparam int unsigned AMT_W   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vend_coin_if #(.AMT_W(AMT_W)) b1 ();
    vend_coin_if #(.AMT_W(AMT_W)) b0 ();

    vend_coin_payer #(.AMT_W(AMT_W), .GAP(1), .TIMEOUT(TIMEOUT)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b1.master)
    );

    vend_coin_payer #(.AMT_W(AMT_W), .GAP(0), .TIMEOUT(TIMEOUT)) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b0.master)
    );

    // price: machine sells once paid >= price on a coin cycle (0 = never sells)
    // stream: first slen coin codes after acceptance, 2 bits each, oldest first
    typedef struct {
        int         amt;
        int         price;
        logic [1:0] chg;
        int         slen;
        int         stream;
        logic       exp_err;
        int         exp_coins;
        int         exp_left;
        logic [1:0] exp_chg;
        logic       is_to;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         pre;
        int         paid;
        int         last_nz;
        int         cyc;
        int         idle;
        logic       sold;
        logic       seen;
        logic [1:0] prev;
        vec_t       e;
        exp_q.push_back(v);
        @(negedge clk);
        chk("req_ready_idle", int'(b1.req_ready), 1);
        b1.req_valid = 1'b1;
        b1.req_amt   = AMT_W'(v.amt);
        @(negedge clk);
        b1.req_valid = 1'b0;
        pre = 0; paid = 0; last_nz = -1; sold = 1'b0; seen = 1'b0; prev = 2'b00;
        for (cyc = 0; cyc < 60 && !seen; cyc++) begin
            b1.sell   = 1'b0;
            b1.change = 2'b00;
            if (cyc < v.slen) pre = (pre << 2) | int'(b1.coin);
            chk("coin_legal", int'(b1.coin == 2'b11), 0);
            chk("coin_spacing", int'(prev != 2'b00 && b1.coin != 2'b00), 0);
            chk("busy", int'(b1.busy), 1);
            if (b1.coin != 2'b00) begin
                paid += (b1.coin == 2'b10) ? 2 : 1;
                last_nz = cyc;
            end
            if (b1.done) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: done with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_err", int'(b1.done_err), int'(e.exp_err));
                    chk("done_coins", int'(b1.done_coins), e.exp_coins);
                    chk("done_left", int'(b1.done_left), e.exp_left);
                    chk("done_change", int'(b1.done_change), int'(e.exp_chg));
                    chk("coin_stream", pre, e.stream);
                    chk("ready_in_done", int'(b1.req_ready), 0);
                    if (e.is_to) begin
                        idle = cyc - last_nz - 1;
                        chk("timeout_idle_range",
                            int'(idle >= int'(TIMEOUT) && idle <= int'(TIMEOUT) + 1), 1);
                    end
                end
            end else if (!sold && v.price != 0 && b1.coin != 2'b00 && paid >= v.price) begin
                b1.sell   = 1'b1;
                b1.change = v.chg;
                sold      = 1'b1;
            end
            prev = b1.coin;
            if (!seen) @(negedge clk);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done for amt %0d", v.amt);
        end
        @(negedge clk);
        chk("done_pulse_end", int'(b1.done), 0);
        chk("ready_after", int'(b1.req_ready), 1);
        chk("busy_after", int'(b1.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.req_valid = 1'b0; b1.req_amt = '0; b1.sell = 1'b0; b1.change = 2'b00;
        b0.req_valid = 1'b0; b0.req_amt = '0; b0.sell = 1'b0; b0.change = 2'b00;

        //          amt price chg  slen stream   err coins left echg  to
        vecs[0] = '{4,  4, 2'b00, 4, 'h88,   1'b0, 2, 0,  2'b00, 1'b0};
        vecs[1] = '{3,  0, 2'b00, 3, 'h21,   1'b1, 2, 0,  2'b00, 1'b1};
        vecs[2] = '{6,  4, 2'b00, 4, 'h88,   1'b0, 2, 2,  2'b00, 1'b0};
        vecs[3] = '{4,  4, 2'b01, 4, 'h88,   1'b0, 2, 0,  2'b01, 1'b0};
        vecs[4] = '{0,  0, 2'b00, 1, 'h0,    1'b1, 0, 0,  2'b00, 1'b0};
        vecs[5] = '{1,  1, 2'b10, 2, 'h4,    1'b0, 1, 0,  2'b10, 1'b0};
        vecs[6] = '{5,  5, 2'b00, 6, 'h884,  1'b0, 3, 0,  2'b00, 1'b0};
        vecs[7] = '{15, 4, 2'b01, 4, 'h88,   1'b0, 2, 11, 2'b01, 1'b0};
        vecs[8] = '{2,  1, 2'b01, 2, 'h8,    1'b0, 1, 0,  2'b01, 1'b0};
        vecs[9] = '{9,  8, 2'b10, 8, 'h8888, 1'b0, 4, 1,  2'b10, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_coin", int'(b1.coin), 0);
        chk("rst_busy", int'(b1.busy), 0);
        chk("rst_done", int'(b1.done), 0);
        chk("rst_done_err", int'(b1.done_err), 0);
        chk("rst_done_coins", int'(b1.done_coins), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(b1.req_ready), 1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Async reset during a coin cycle
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_amt = AMT_W'(4);
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("mid_send_coin", int'(b1.coin), 2);
        rstn = 1'b0;
        #1;
        chk("rst_send_coin", int'(b1.coin), 0);
        chk("rst_send_busy", int'(b1.busy), 0);
        chk("rst_send_coins", int'(b1.done_coins), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Async reset during the gap after the first coin
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_amt = AMT_W'(6);
        @(negedge clk);
        b1.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_gap_busy", int'(b1.busy), 1);
        rstn = 1'b0;
        #1;
        chk("rst_gap_coin", int'(b1.coin), 0);
        chk("rst_gap_busy", int'(b1.busy), 0);
        @(negedge clk);
        rstn = 1'b1;
        run_vec(vecs[0]);

        // Back-to-back coins with no gap, then timeout
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_amt = AMT_W'(5);
        @(negedge clk);
        b0.req_valid = 1'b0;
        chk("g0_coin0", int'(b0.coin), 2);
        @(negedge clk);
        chk("g0_coin1", int'(b0.coin), 2);
        @(negedge clk);
        chk("g0_coin2", int'(b0.coin), 1);
        @(negedge clk);
        chk("g0_coin3", int'(b0.coin), 0);
        for (int i = 0; i < 30 && !b0.done; i++) @(negedge clk);
        chk("g0_done", int'(b0.done), 1);
        chk("g0_err", int'(b0.done_err), 1);
        chk("g0_coins", int'(b0.done_coins), 3);
        chk("g0_left", int'(b0.done_left), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
